hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage interlock: one latency down-counter per GPR, per FPR and for the
// FP condition flag. Decides stall/issue for the instruction sitting in decode.
module hazard_sb_cnt #(
    parameter int LAT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold_i,
    input  logic             load_i,
    input  logic [LAT_W-1:0] val_i,
    output logic             busy_o,
    output logic             pend_o
);
    logic [LAT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (load_i)
                cnt_d = val_i;
            else if (cnt_q != '0)
                cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign busy_o = (cnt_q != '0);
    // At 1 the result is forwardable this cycle, so readers only wait above 1.
    assign pend_o = (cnt_q > LAT_W'(1));
endmodule

module hazard_scoreboard #(
    parameter int LAT_W = 3,
    parameter int NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             flush,
    input  logic             ex_stall,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic             d_from_gpr,
    input  logic             d_from_fpr,
    input  logic             d_to_gpr,
    input  logic             d_to_fpr,
    input  logic             s_from_gpr,
    input  logic             s_from_fpr,
    input  logic             t_from_gpr,
    input  logic             t_from_fpr,
    input  logic             from_fcond,
    input  logic             to_fcond,
    input  logic [LAT_W-1:0] latency,
    output logic             stall,
    output logic             issue,
    output logic [NREG-1:0]  busy_gpr,
    output logic [NREG-1:0]  busy_fpr,
    output logic             busy_fcond
);
    logic [NREG-1:0] pend_gpr, pend_fpr, ld_gpr, ld_fpr;
    logic            pend_fc, ld_fc;
    logic            go, raw, waw, hazard, ld_en;

    assign go = id_valid & ~flush;

    assign raw = (s_from_gpr & pend_gpr[rs]) | (s_from_fpr & pend_fpr[rs])
               | (t_from_gpr & pend_gpr[rt]) | (t_from_fpr & pend_fpr[rt])
               | (d_from_gpr & pend_gpr[rd]) | (d_from_fpr & pend_fpr[rd])
               | (from_fcond & pend_fc);

    // A second writer waits for the counter to fully drain, so a load never
    // races a decrement on the same counter.
    assign waw = (d_to_gpr & busy_gpr[rd]) | (d_to_fpr & busy_fpr[rd])
               | (to_fcond & busy_fcond);

    assign hazard = raw | waw;
    assign stall  = go & hazard;
    assign issue  = go & ~hazard & ~ex_stall;
    assign ld_en  = issue & (latency != '0);
    assign ld_fc  = ld_en & to_fcond;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        localparam logic [4:0] IDX = 5'(g);
        // r0 never loads, so its counter stays 0 from reset onward.
        assign ld_gpr[g] = ld_en & d_to_gpr & (rd == IDX) & (g != 0);
        assign ld_fpr[g] = ld_en & d_to_fpr & (rd == IDX);

        hazard_sb_cnt #(.LAT_W(LAT_W)) u_gpr (
            .clk(clk), .rst(rst), .hold_i(ex_stall), .load_i(ld_gpr[g]),
            .val_i(latency), .busy_o(busy_gpr[g]), .pend_o(pend_gpr[g]));

        hazard_sb_cnt #(.LAT_W(LAT_W)) u_fpr (
            .clk(clk), .rst(rst), .hold_i(ex_stall), .load_i(ld_fpr[g]),
            .val_i(latency), .busy_o(busy_fpr[g]), .pend_o(pend_fpr[g]));
    end

    hazard_sb_cnt #(.LAT_W(LAT_W)) u_fcond (
        .clk(clk), .rst(rst), .hold_i(ex_stall), .load_i(ld_fc),
        .val_i(latency), .busy_o(busy_fcond), .pend_o(pend_fc));
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: RAW/WAW interlock, r0, fcond,
// ex_stall freeze, flush and asynchronous reset.
module tb_hazard_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, flush, ex_stall;
    logic [4:0]  rd, rs, rt;
    logic        d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr;
    logic        s_from_gpr, s_from_fpr, t_from_gpr, t_from_fpr;
    logic        from_fcond, to_fcond;
    logic [2:0]  latency;
    logic        stall, issue, busy_fcond;
    logic [31:0] busy_gpr, busy_fpr;
    int          total = 0;
    int          bad = 0;

    hazard_scoreboard #(.LAT_W(3), .NREG(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .flush(flush),
        .ex_stall(ex_stall), .rd(rd), .rs(rs), .rt(rt),
        .d_from_gpr(d_from_gpr), .d_from_fpr(d_from_fpr),
        .d_to_gpr(d_to_gpr), .d_to_fpr(d_to_fpr),
        .s_from_gpr(s_from_gpr), .s_from_fpr(s_from_fpr),
        .t_from_gpr(t_from_gpr), .t_from_fpr(t_from_fpr),
        .from_fcond(from_fcond), .to_fcond(to_fcond), .latency(latency),
        .stall(stall), .issue(issue), .busy_gpr(busy_gpr),
        .busy_fpr(busy_fpr), .busy_fcond(busy_fcond));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_valid = 0; flush = 0; ex_stall = 0; rd = 0; rs = 0; rt = 0;
        d_from_gpr = 0; d_from_fpr = 0; d_to_gpr = 0; d_to_fpr = 0;
        s_from_gpr = 0; s_from_fpr = 0; t_from_gpr = 0; t_from_fpr = 0;
        from_fcond = 0; to_fcond = 0; latency = 0;
    endtask

    // Advance one edge; inputs change 2ns after it, checks 1ns later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic si(input string tag, input logic s, input logic i);
        #1;
        chk({tag, "_stall"}, {31'd0, stall}, {31'd0, s});
        chk({tag, "_issue"}, {31'd0, issue}, {31'd0, i});
    endtask

    initial begin
        clr();
        rst = 1;
        #3;
        chk("rst_bgpr", busy_gpr, 32'd0);
        chk("rst_bfpr", busy_fpr, 32'd0);
        chk("rst_bfc", {31'd0, busy_fcond}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        rst = 0;
        tick();

        // FADD f3 lat 3, then FMUL reading f3
        id_valid = 1; rd = 3; d_to_fpr = 1; latency = 3;
        si("fadd", 0, 1);
        tick(); clr();
        id_valid = 1; rs = 3; s_from_fpr = 1; rd = 4; d_to_fpr = 1; latency = 2;
        si("fmul_c1", 1, 0);
        chk("f3_c1", {31'd0, busy_fpr[3]}, 32'd1);
        tick();
        si("fmul_c2", 1, 0);
        chk("f3_c2", {31'd0, busy_fpr[3]}, 32'd1);
        tick();
        si("fmul_c3", 0, 1);
        chk("f3_c3", {31'd0, busy_fpr[3]}, 32'd1);
        tick(); clr();
        #1;
        chk("f3_c4", {31'd0, busy_fpr[3]}, 32'd0);
        chk("f4_load", busy_fpr, 32'h10);
        tick(); tick();
        chk("f4_drain", busy_fpr, 32'd0);

        // ADDI r0 lat 2, then ADD reading r0
        id_valid = 1; rd = 0; d_to_gpr = 1; latency = 2;
        si("addi_r0", 0, 1);
        tick(); clr();
        chk("r0_busy", busy_gpr, 32'd0);
        id_valid = 1; rs = 0; s_from_gpr = 1; rd = 1; d_to_gpr = 1; latency = 0;
        si("add_r0", 0, 1);
        tick(); clr();
        chk("lat0_noload", busy_gpr, 32'd0);

        // FCLT then BC1T
        id_valid = 1; to_fcond = 1; latency = 2;
        si("fclt", 0, 1);
        tick(); clr();
        id_valid = 1; from_fcond = 1;
        si("bc1t_c1", 1, 0);
        chk("fc_c1", {31'd0, busy_fcond}, 32'd1);
        tick();
        si("bc1t_c2", 0, 1);
        chk("fc_c2", {31'd0, busy_fcond}, 32'd1);
        tick(); clr();
        #1;
        chk("fc_c3", {31'd0, busy_fcond}, 32'd0);
        tick();

        // LW r5 lat 2 under a 3-cycle ex_stall
        id_valid = 1; rd = 5; d_to_gpr = 1; latency = 2;
        si("lw", 0, 1);
        tick(); clr();
        id_valid = 1; rs = 5; s_from_gpr = 1; rd = 6; d_to_gpr = 1; ex_stall = 1;
        for (int c = 0; c < 3; c++) begin
            si("lw_dep_exst", 1, 0);
            chk("r5_held", busy_gpr, 32'h20);
            tick();
        end
        ex_stall = 0;
        si("lw_dep_a", 1, 0);
        tick();
        si("lw_dep_b", 0, 1);
        chk("r5_last", busy_gpr, 32'h20);
        tick(); clr();
        #1;
        chk("r5_clear", busy_gpr, 32'd0);
        id_valid = 1; rs = 2; s_from_gpr = 1; ex_stall = 1;
        si("exst_nohaz", 0, 0);
        tick(); clr();

        // WAW on f7, then flush of a hazardous reader
        id_valid = 1; rd = 7; d_to_fpr = 1; latency = 3;
        si("w1_f7", 0, 1);
        tick(); clr();
        id_valid = 1; rd = 7; d_to_fpr = 1; latency = 2;
        si("waw_c1", 1, 0);
        tick();
        si("waw_c2", 1, 0);
        tick();
        si("waw_c3", 1, 0);
        tick();
        si("waw_c4", 0, 1);
        tick(); clr();
        #1;
        chk("f7_reload", busy_fpr, 32'h80);
        id_valid = 1; rs = 7; s_from_fpr = 1; rt = 7; t_from_fpr = 1; flush = 1;
        si("flush", 0, 0);
        tick();
        chk("f7_flush_dn", busy_fpr, 32'h80);
        tick(); clr();
        #1;
        chk("f7_done", busy_fpr, 32'd0);

        // Async reset while r9 counter = 4
        id_valid = 1; rd = 9; d_to_gpr = 1; latency = 4;
        si("ld_r9", 0, 1);
        tick(); clr();
        chk("r9_busy", busy_gpr, 32'h200);
        rst = 1;
        #1;
        chk("r9_async", busy_gpr, 32'd0);
        id_valid = 1; rs = 9; s_from_gpr = 1;
        #1 rst = 0;
        si("r9_reader", 0, 1);
        tick(); clr();
        chk("r9_after", busy_gpr, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
